rsa_modexp_core: RTL
====================

# rsa_modexp_core

Parametrised modular-exponentiation engine computing o_a_pow_e = i_a^i_e mod i_n with right-to-left binary exponentiation. It contains its own bit-serial Montgomery multiplier and the a·2^WIDTH mod n pre-scaler, so no external multiply or transform handshake exists. It sits between the RSA wrapper's operand registers and its result register and replaces the fixed-256-bit core. It adds a WIDTH parameter, a configurable exponent length, deterministic latency, a busy flag and input locking while busy.

## Interface
- WIDTH, 256, operand and modulus width in bits (≥4)
- E_BITS, WIDTH, number of exponent LSBs scanned (1..WIDTH)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_start  in  1  start request; sampled only in IDLE
- i_a  in  WIDTH  base; must be < i_n
- i_e  in  WIDTH  exponent; only bits [E_BITS-1:0] are used
- i_n  in  WIDTH  modulus; must be odd and > 1
- o_a_pow_e  out  WIDTH  result; held from DONE until the next accepted start
- o_finished  out  1  one-cycle pulse when o_a_pow_e becomes valid
- o_busy  out  1  high from the cycle after start acceptance through DONE inclusive

## Operation
- States: IDLE, PREP, MONT_M, MONT_T, DONE.
- **IDLE:** if i_start=1, capture i_a→t, i_e, i_n into internal registers and set m=1 and bit index k=0, then go to PREP. Inputs are not sampled again until the next IDLE.
- **PREP:** runs WIDTH cycles. Each cycle: t = 2t; if t ≥ n then t -= n. Use a WIDTH+1-bit intermediate. Result: t = a·2^WIDTH mod n. Go to MONT_M if e[0]=1, else to MONT_T.
- **Montgomery step Mont(x,y) = x·y·2^-WIDTH mod n:** WIDTH+1 cycles on a WIDTH+2-bit accumulator acc (cleared on entry).
  - Iteration cycles i=0..WIDTH-1: if x[i], acc += y; if acc is odd, acc += n; then acc >>= 1.
  - Final cycle: if acc ≥ n, acc -= n.
- **MONT_M:** m = Mont(m,t). Then go to MONT_T.
- **MONT_T:** t = Mont(t,t). Then k += 1.
  - If the new k = E_BITS, go to DONE.
  - Otherwise go to MONT_M if e[k]=1, else to MONT_T.
- **DONE:** one cycle. o_a_pow_e = m, o_finished = 1, then go to IDLE.
- Why this works: m stays in the normal domain and t in the Montgomery domain, so the final m equals a^e mod n with no conversion back.
- The final squaring is always executed; this keeps the latency formula uniform.
- Edge values:
  - e masked to 0 → result 1.
  - a = 0 → result 0 whenever e ≠ 0.
- Illegal operands (n even, n ≤ 1, a ≥ n): the result is undefined, but the FSM must complete with the same latency and must not hang.
- i_start asserted while busy is ignored and is not queued.

## Timing
- Reset (i_rst=0 at a clock edge): state = IDLE; o_a_pow_e = 0, o_finished = 0, o_busy = 0; all internal registers cleared.
- Reset mid-operation aborts the computation immediately. There is no o_finished for the aborted operation.
- Let the start-acceptance edge be cycle 0. Then:
  - PREP occupies cycles 1..WIDTH.
  - Each scanned bit costs (WIDTH+1)·(1+e[k]) cycles.
  - DONE occurs at cycle L = 1 + WIDTH + (WIDTH+1)·(E_BITS + popcount(e[E_BITS-1:0])).
- o_finished is high exactly in cycle L. o_busy falls in cycle L+1.
- A new i_start is accepted in cycle L+1 at the earliest. i_start held high back-to-back therefore yields one operation per L+1 cycles.
- o_a_pow_e is updated only in DONE and stays stable otherwise, including during the next operation until that operation's DONE.

## Test plan
- WIDTH=8, E_BITS=8; a=3, e=5, n=253 → o_a_pow_e=243, o_finished pulse exactly at cycle 99, o_busy high cycles 1..99.
- WIDTH=8; a=5, e=3, n=13 → 8 at cycle 1+8+9·(8+2)=99; then e=0 → 1 at cycle 81; then a=0, e=7 → 0.
- WIDTH=8; pulse i_start again at cycles 10 and 50 of a running operation with different operands → ignored; the first result is unchanged and no extra o_finished appears.
- WIDTH=8; drive i_rst=0 at cycle 40 → next cycle all outputs 0 and state IDLE; a fresh start then completes normally with correct value and latency.
- WIDTH=8, E_BITS=4; e=0xF3 → only 0x3 is used: a=2, n=11 → 8, latency 1+8+9·(4+2)=63.
- WIDTH=256; 50 random odd n, a<n, random e compared against a software pow(a,e,n) → all match, and each latency matches L.

Source files
------------

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation a^e mod n, right-to-left binary method with a
// bit-serial Montgomery multiplier and built-in a*2^WIDTH mod n pre-scaler.
module rsa_modexp_core #(
    parameter int WIDTH  = 256,
    parameter int E_BITS = WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_e,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_e,
    output logic             o_finished,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH + 1) + 1;

    typedef enum logic [2:0] {
        IDLE, PREP, MONT_M, MONT_T, DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] t, m, e, n, xs;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    cnt, k;

    logic [WIDTH:0]   dbl, dbl_sub;
    logic [WIDTH-1:0] t_dbl, mont_r;
    logic [WIDTH+1:0] acc_y, acc_n, acc_sub;
    logic [CW-1:0]    k_nxt;

    // t is the Montgomery-domain running power and also the y operand
    always_comb begin
        dbl     = {t, 1'b0};
        dbl_sub = dbl - {1'b0, n};
        t_dbl   = WIDTH'((dbl >= {1'b0, n}) ? dbl_sub : dbl);
        acc_y   = acc + (xs[0] ? {2'b00, t} : '0);
        acc_n   = acc_y + (acc_y[0] ? {2'b00, n} : '0);
        acc_sub = acc - {2'b00, n};
        mont_r  = WIDTH'((acc >= {2'b00, n}) ? acc_sub : acc);
        k_nxt   = k + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            t          <= '0;
            m          <= '0;
            e          <= '0;
            n          <= '0;
            xs         <= '0;
            acc        <= '0;
            cnt        <= '0;
            k          <= '0;
            o_a_pow_e  <= '0;
            o_finished <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            unique case (state)
                IDLE: begin
                    o_busy <= 1'b0;
                    if (i_start) begin
                        t     <= i_a;
                        e     <= i_e;
                        n     <= i_n;
                        m     <= WIDTH'(1);
                        k     <= '0;
                        cnt   <= '0;
                        state <= PREP;
                    end
                end
                PREP: begin
                    o_busy <= 1'b1;
                    t      <= t_dbl;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt <= '0;
                        acc <= '0;
                        if (e[0]) begin
                            xs    <= m;
                            state <= MONT_M;
                        end else begin
                            xs    <= t_dbl;
                            state <= MONT_T;
                        end
                    end
                end
                MONT_M, MONT_T: begin
                    if (cnt != CW'(WIDTH)) begin
                        acc <= acc_n >> 1;
                        xs  <= xs >> 1;
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        acc <= '0;
                        if (state == MONT_M) begin
                            m     <= mont_r;
                            xs    <= t;
                            state <= MONT_T;
                        end else begin
                            // e shifts so e[1] is the next scanned bit
                            t <= mont_r;
                            k <= k_nxt;
                            e <= e >> 1;
                            if (k_nxt == CW'(E_BITS)) begin
                                state <= DONE;
                            end else if (e[1]) begin
                                xs    <= m;
                                state <= MONT_M;
                            end else begin
                                xs    <= mont_r;
                                state <= MONT_T;
                            end
                        end
                    end
                end
                DONE: begin
                    o_a_pow_e  <= m;
                    o_finished <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
